// File: rtl/binarize_stream.sv
// binarize_stream: registered, back-pressurable per-channel threshold
// binarizer that maps signed pre-activations to +1/-1 activations.
//
// Parameters
//   DEPTH        input word width per channel (signed, >= 2)
//   TARGET_DEPTH output word width per channel (signed, >= 2)
//   WIDTH        channels per beat (>= 1)
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   in_valid      input beat present
//   in_ready      block accepts a beat this cycle
//   in_data       WIDTH x DEPTH signed, channel c at [c*DEPTH +: DEPTH]
//   thr_we        threshold write strobe
//   thr_addr      channel index to write (writes >= WIDTH are dropped)
//   thr_data      signed threshold value
//   out_valid     output beat present
//   out_ready     downstream accepts the beat
//   out_data      WIDTH x TARGET_DEPTH, +1 = 1, -1 = all ones
//   out_bits      bit c set when channel c is +1
//   out_pos_cnt   number of +1 channels in the beat
//
// Build option
//   BINARIZE_THR_EN  when defined, a programmable threshold file is
//                    built; otherwise every threshold is constant 0
//                    (plain sign function) and thr_* are ignored.

module binarize_stream #(
   parameter int DEPTH        = 32,
   parameter int TARGET_DEPTH = 2,
   parameter int WIDTH        = 3,
   localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
   localparam int CW = $clog2(WIDTH + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH*DEPTH-1:0]        in_data,
   input  logic                          thr_we,
   input  logic [AW-1:0]                 thr_addr,
   input  logic [DEPTH-1:0]              thr_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH*TARGET_DEPTH-1:0] out_data,
   output logic [WIDTH-1:0]              out_bits,
   output logic [CW-1:0]                 out_pos_cnt
);

   localparam logic [TARGET_DEPTH-1:0] POS = TARGET_DEPTH'(1);
   localparam logic [TARGET_DEPTH-1:0] NEG = '1;

   logic signed [DEPTH-1:0] thr_eff [WIDTH];

`ifdef BINARIZE_THR_EN
   logic signed [DEPTH-1:0] thr [WIDTH];

   // Address decode against every legal index, so an
   // out-of-range address simply matches nothing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++)
            thr[i] <= '0;
      end else if (thr_we) begin
         for (int i = 0; i < WIDTH; i++)
            if (thr_addr == AW'(i))
               thr[i] <= thr_data;
      end
   end

   always_comb begin
      for (int i = 0; i < WIDTH; i++)
         thr_eff[i] = thr[i];
   end
`else
   logic unused_thr;
   assign unused_thr = ^{thr_we, thr_addr, thr_data};

   always_comb begin
      for (int i = 0; i < WIDTH; i++)
         thr_eff[i] = '0;
   end
`endif

   // Compare uses the threshold currently in the file, so a
   // write on the accept edge only affects later beats.
   logic [WIDTH-1:0] cmp;

   always_comb begin
      cmp = '0;
      for (int c = 0; c < WIDTH; c++)
         cmp[c] = $signed(in_data[c*DEPTH +: DEPTH]) >= thr_eff[c];
   end

   logic             valid_a;
   logic [WIDTH-1:0] bits_a;
   logic             ready_a;
   logic             accept;
   logic             advance;

   assign ready_a  = !out_valid || out_ready;
   assign in_ready = !valid_a || ready_a;
   assign accept   = in_valid && in_ready;
   assign advance  = valid_a && ready_a;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_a <= 1'b0;
         bits_a  <= '0;
      end else if (accept) begin
         valid_a <= 1'b1;
         bits_a  <= cmp;
      end else if (advance) begin
         valid_a <= 1'b0;
      end
   end

   logic [CW-1:0]                 cnt_a;
   logic [WIDTH*TARGET_DEPTH-1:0] data_a;

   always_comb begin
      cnt_a  = '0;
      data_a = '0;
      for (int c = 0; c < WIDTH; c++) begin
         cnt_a = cnt_a + CW'(bits_a[c]);
         data_a[c*TARGET_DEPTH +: TARGET_DEPTH] = bits_a[c] ? POS : NEG;
      end
   end

   // Output registers only load on advance, which keeps them
   // frozen for the whole of a downstream stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_bits    <= '0;
         out_data    <= '0;
         out_pos_cnt <= '0;
      end else if (advance) begin
         out_valid   <= 1'b1;
         out_bits    <= bits_a;
         out_data    <= data_a;
         out_pos_cnt <= cnt_a;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_binarize_stream.sv
// tb_binarize_stream: directed and random checks of binarize_stream
// against a beat-level queue model of the pipeline.

module tb_binarize_stream;

   localparam int D = 32;
   localparam int T = 2;
   localparam int W = 3;

`ifdef BINARIZE_THR_EN
   localparam bit THR_ON = 1'b1;
`else
   localparam bit THR_ON = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W*D-1:0] in_data;
   logic           thr_we;
   logic [1:0]     thr_addr;
   logic [D-1:0]   thr_data;
   logic           out_valid;
   logic           out_ready;
   logic [W*T-1:0] out_data;
   logic [W-1:0]   out_bits;
   logic [1:0]     out_pos_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   binarize_stream #(
      .DEPTH(D), .TARGET_DEPTH(T), .WIDTH(W)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .thr_we(thr_we), .thr_addr(thr_addr), .thr_data(thr_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_bits(out_bits),
      .out_pos_cnt(out_pos_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [95:0] act,
                      input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timed out", nm);
   endtask

   // Model: beats in flight, oldest first; age counts edges since
   // accept. The oldest beat reaches the output one edge after accept.
   typedef struct {
      logic [W-1:0] bits;
      int           age;
   } item_t;

   item_t q[$];
   int    m_thr [W];

   function automatic logic [W-1:0] ref_bits(input logic [W*D-1:0] d);
      logic [W-1:0] b;
      for (int c = 0; c < W; c++)
         b[c] = $signed(d[c*D +: D]) >= m_thr[c];
      return b;
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            q.delete();
            for (int i = 0; i < W; i++) m_thr[i] = 0;
         end else begin
            bit           rdy;
            bit           ov;
            logic [W-1:0] nb;
            rdy = (q.size() < 2) || out_ready;
            ov  = (q.size() > 0) && (q[0].age >= 1);
            nb  = ref_bits(in_data);
            if (ov && out_ready) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (in_valid && rdy) q.push_back('{nb, 0});
            if (THR_ON && thr_we && int'(thr_addr) < W)
               m_thr[thr_addr] = $signed(thr_data);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_bits", out_bits, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_cnt", out_pos_cnt, 0);
         end else begin
            bit             ov;
            logic [W*T-1:0] ed;
            ov = (q.size() > 0) && (q[0].age >= 1);
            chk("in_ready", in_ready, (q.size() < 2) || out_ready);
            chk("out_valid", out_valid, ov);
            if (ov) begin
               for (int c = 0; c < W; c++)
                  ed[c*T +: T] = q[0].bits[c] ? 2'b01 : 2'b11;
               chk("out_bits", out_bits, q[0].bits);
               chk("out_data", out_data, ed);
               chk("out_cnt", out_pos_cnt, $countones(q[0].bits));
               chk("cnt_vs_bits", out_pos_cnt, $countones(out_bits));
            end
         end
      end
   end

   function automatic logic [W*D-1:0] bt(input int a0, input int a1,
                                         input int a2);
      return {a2, a1, a0};
   endfunction

   function automatic logic [D-1:0] rnd_ch();
      case ($urandom_range(0, 5))
         0: return 32'h8000_0000;
         1: return 32'h7fff_ffff;
         2: return 32'd0;
         3: return 32'hffff_ffff;
         4: return 32'd10;
         default: return $urandom();
      endcase
   endfunction

   task automatic send(input logic [W*D-1:0] d, input logic we = 1'b0,
                       input logic [1:0] a = 2'd0,
                       input logic [D-1:0] td = '0);
      bit ok;
      int n;
      ok = 1'b0;
      n  = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d;
      thr_we   = we;
      thr_addr = a;
      thr_data = td;
      while (!ok && n < 20) begin
         @(negedge clk);
         ok = in_ready;
         n++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      thr_we   = 1'b0;
      if (!ok) tmo("send");
   endtask

   task automatic expect_out(input string nm, input logic [W-1:0] b,
                             input logic [W*T-1:0] d,
                             input logic [1:0] c);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 10);
      if (!out_valid) tmo(nm);
      else begin
         chk({nm, "_bits"}, out_bits, b);
         chk({nm, "_data"}, out_data, d);
         chk({nm, "_cnt"}, out_pos_cnt, c);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      thr_we    = 1'b0;
      out_ready = 1'b1;
      while (q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) tmo("drain");
   endtask

   task automatic t_basic();
      send(bt(-1, 0, 5));
      @(negedge clk);
      chk("lat_a_only", out_valid, 0);
      @(negedge clk);
      chk("lat_out_valid", out_valid, 1);
      chk("t1_bits", out_bits, 3'b110);
      chk("t1_data", out_data, 6'b010111);
      chk("t1_cnt", out_pos_cnt, 2'd2);
   endtask

   task automatic t_thr();
      send(bt(0, 10, 9), 1'b1, 2'd1, 32'd10);
      expect_out("same_cycle_wr", 3'b111, 6'b010101, 2'd3);
      send(bt(9, 10, 0));
      expect_out("thr_equal", 3'b111, 6'b010101, 2'd3);
      send(bt(9, 9, 0));
      expect_out("thr_below", THR_ON ? 3'b101 : 3'b111,
                 THR_ON ? 6'b011101 : 6'b010101,
                 THR_ON ? 2'd2 : 2'd3);
      send(bt(-1, -1, -1), 1'b1, 2'd3, 32'h7fff_ffff);
      expect_out("all_neg", 3'b000, 6'b111111, 2'd0);
      send(bt(0, 10, 0));
      expect_out("addr3_ignored", 3'b111, 6'b010101, 2'd3);
      send(bt(5, 5, 5), 1'b1, 2'd0, 32'd100);
      expect_out("thr0_old", 3'b111, 6'b010101, 2'd3);
      send(bt(5, 5, 5));
      expect_out("thr0_new", THR_ON ? 3'b100 : 3'b111,
                 THR_ON ? 6'b011111 : 6'b010101,
                 THR_ON ? 2'd1 : 2'd3);
   endtask

   task automatic t_stall();
      logic [W*D-1:0] sb [4];
      int k;
      int it;
      bit ok;
      k  = 0;
      it = 0;
      sb[0] = bt(1, -1, -1);
      sb[1] = bt(-1, 200, -1);
      sb[2] = bt(300, 300, 300);
      sb[3] = bt(-5, -5, 200);
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         in_valid = (k < 4);
         if (k < 4) in_data = sb[k];
         @(negedge clk);
         ok = in_valid && in_ready;
         @(posedge clk); #1;
         if (ok) k++;
      end
      chk("stall_accepted", k, 2);
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      while (k < 4 && it < 20) begin
         in_valid = 1'b1;
         in_data  = sb[k];
         @(negedge clk);
         ok = in_ready;
         @(posedge clk); #1;
         if (ok) k++;
         it++;
      end
      in_valid = 1'b0;
      chk("release_cycles", it, 2);
      drain();
   endtask

   task automatic t_random();
      int  sent;
      int  cyc;
      bit  acc;
      sent = 0;
      cyc  = 0;
      @(posedge clk); #1;
      while (sent < 1000 && cyc < 20000) begin
         if (!in_valid && $urandom_range(0, 9) < 7) begin
            in_valid = 1'b1;
            in_data  = {rnd_ch(), rnd_ch(), rnd_ch()};
         end
         out_ready = $urandom_range(0, 9) < 7;
         thr_we    = $urandom_range(0, 15) == 0;
         thr_addr  = 2'($urandom_range(0, 3));
         thr_data  = rnd_ch();
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            sent++;
            in_valid = 1'b0;
         end
         cyc++;
      end
      chk("rand_beats", sent, 1000);
      drain();
   endtask

   task automatic t_reset();
      @(posedge clk); #1;
      thr_we    = 1'b1;
      thr_addr  = 2'd1;
      thr_data  = 32'd10;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = bt(7, 7, 7);
      @(posedge clk); #1;
      thr_we = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      chk("full_out_valid", out_valid, 1);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_out_bits", out_bits, 0);
      chk("arst_out_data", out_data, 0);
      chk("arst_out_cnt", out_pos_cnt, 0);
      repeat (2) @(negedge clk);
      in_data   = bt(-1, 5, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_lat1", out_valid, 0);
      @(negedge clk);
      chk("post_rst_lat2", out_valid, 1);
      chk("post_rst_thr0", out_bits, 3'b110);
      chk("post_rst_data", out_data, 6'b010111);
      send(bt(-1, -1, -1));
      expect_out("post_rst_neg", 3'b000, 6'b111111, 2'd0);
      drain();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      thr_we    = 1'b0;
      thr_addr  = '0;
      thr_data  = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("init_out_valid", out_valid, 0);
      chk("init_in_ready", in_ready, 1);
      chk("init_out_data", out_data, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      t_basic();
      t_thr();
      t_stall();
      t_random();
      t_reset();
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
